instr_sequencer: RTL and testbench

//   Multi-cycle fetch/decode/execute controller for the register-file processor datapath.
//   - Fetches one 32-bit instruction per step from instruction memory over a req/ack handshake.
//   - Decodes its control fields into one-cycle strobes for the processor.
//   - Owns the PC and updates it sequentially or by the processor-supplied branch target.
//   - Sits between instruction memory and the processor; replaces free-running PC logic.

---
 rtl/instr_sequencer.sv | 172 +++++++++++++++++
 tb/tb_instr_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute controller.
// Owns the PC, fetches over req/ack, emits one-cycle EXEC strobes.
module instr_sequencer #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic             mem_req,
    output logic [PC_W-1:0]  mem_addr,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    input  logic [4:0]       target,
    output logic             alu_sum,
    output logic             wb,
    output logic             mem_wb,
    output logic             imm_wb,
    output logic             eq_in,
    output logic             lt_in,
    output logic             reset_st,
    output logic             set_st,
    output logic [4:0]       dest,
    output logic [4:0]       source1,
    output logic [4:0]       source2,
    output logic [PC_W-1:0]  pc,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        HALT   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  w_pc_nx;
    logic [31:0]      r_ir;
    logic [31:0]      w_ir_nx;
    logic [CNT_W-1:0] r_retired;
    logic [CNT_W-1:0] w_ret_nx;
    logic             r_halted;
    logic             w_halt_nx;
    logic             r_mem_req;
    logic             w_req_nx;
    logic [7:0]       r_strb;
    logic [7:0]       w_strb_nx;
    logic [4:0]       r_dest;
    logic [4:0]       w_dest_nx;
    logic [4:0]       r_src2;
    logic [4:0]       w_src2_nx;
    logic             w_unused_ir;

    // ir[29:18] carries no control meaning
    assign w_unused_ir = ^r_ir[29:18];

    // Next-state and next-register computation; strobes default to 0
    always_comb begin
        w_state_nx = r_state;
        w_pc_nx    = r_pc;
        w_ir_nx    = r_ir;
        w_ret_nx   = r_retired;
        w_halt_nx  = r_halted;
        w_req_nx   = r_mem_req;
        w_strb_nx  = '0;
        w_dest_nx  = '0;
        w_src2_nx  = '0;
        unique case (r_state)
            IDLE: begin
                if (run) begin
                    w_state_nx = FETCH;
                    w_req_nx   = 1'b1;
                end
            end
            FETCH: begin
                if (mem_ack) begin
                    w_ir_nx    = mem_rdata;
                    w_req_nx   = 1'b0;
                    w_state_nx = DECODE;
                end
            end
            DECODE: begin
                w_strb_nx  = r_ir[7:0];
                w_dest_nx  = r_ir[12:8];
                w_src2_nx  = r_ir[17:13];
                w_state_nx = EXEC;
            end
            EXEC: begin
                w_ret_nx = r_retired + CNT_W'(1);
                if (r_ir[30]) begin
                    w_halt_nx  = 1'b1;
                    w_state_nx = HALT;
                end else begin
                    if (r_ir[31]) begin
                        w_pc_nx = r_pc + PC_W'(target);
                    end else begin
                        w_pc_nx = r_pc + PC_W'(1);
                    end
                    if (run) begin
                        w_state_nx = FETCH;
                        w_req_nx   = 1'b1;
                    end else begin
                        w_state_nx = IDLE;
                    end
                end
            end
            HALT: begin
                w_state_nx = HALT;
            end
            default: begin
                w_state_nx = IDLE;
                w_req_nx   = 1'b0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Datapath registers: pc, ir, counters, request and strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_retired <= '0;
            r_halted  <= 1'b0;
            r_mem_req <= 1'b0;
            r_strb    <= '0;
            r_dest    <= '0;
            r_src2    <= '0;
        end else begin
            r_pc      <= w_pc_nx;
            r_ir      <= w_ir_nx;
            r_retired <= w_ret_nx;
            r_halted  <= w_halt_nx;
            r_mem_req <= w_req_nx;
            r_strb    <= w_strb_nx;
            r_dest    <= w_dest_nx;
            r_src2    <= w_src2_nx;
        end
    end

    assign mem_req  = r_mem_req;
    assign mem_addr = r_pc;
    assign pc       = r_pc;
    assign halted   = r_halted;
    assign retired  = r_retired;
    assign alu_sum  = r_strb[0];
    assign wb       = r_strb[1];
    assign mem_wb   = r_strb[2];
    assign imm_wb   = r_strb[3];
    assign eq_in    = r_strb[4];
    assign lt_in    = r_strb[5];
    assign reset_st = r_strb[6];
    assign set_st   = r_strb[7];
    assign dest     = r_dest;
    assign source1  = r_dest;
    assign source2  = r_src2;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer.
// Table of instructions plus hand sequences for reset, halt and wrap.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [4:0]  target;
    logic        alu_sum, wb, mem_wb, imm_wb;
    logic        eq_in, lt_in, reset_st, set_st;
    logic [4:0]  dest, source1, source2;
    logic [31:0] pc;
    logic        halted;
    logic [15:0] retired;
    logic [7:0]  w_strb;

    logic        run2;
    logic        req2;
    logic [3:0]  addr2;
    logic        ack2;
    logic [31:0] rdata2;
    logic [4:0]  target2;
    logic        s_alu, s_wb, s_mwb, s_iwb;
    logic        s_eq, s_lt, s_rst, s_set;
    logic [4:0]  s_dest, s_src1, s_src2;
    logic [3:0]  pc2;
    logic        halted2;
    logic [1:0]  retired2;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [31:0] word;
        logic [4:0]  tgt;
        int          dly;
        bit          run_nx;
    } vec_t;

    typedef struct {
        logic [7:0]  strb;
        logic [4:0]  dest;
        logic [4:0]  src2;
        logic [31:0] pc;
        logic [15:0] ret;
        logic        halt;
    } exp_t;

    vec_t        tbl[8];
    exp_t        sb[$];
    logic [31:0] m_pc;
    logic [15:0] m_ret;

    always #5 clk = ~clk;

    assign w_strb = {set_st, reset_st, lt_in, eq_in,
                     imm_wb, mem_wb, wb, alu_sum};

    instr_sequencer #(.PC_W(32), .RESET_PC(32'd0), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .target(target),
        .alu_sum(alu_sum), .wb(wb), .mem_wb(mem_wb), .imm_wb(imm_wb),
        .eq_in(eq_in), .lt_in(lt_in), .reset_st(reset_st), .set_st(set_st),
        .dest(dest), .source1(source1), .source2(source2),
        .pc(pc), .halted(halted), .retired(retired)
    );

    instr_sequencer #(.PC_W(4), .RESET_PC(4'd0), .CNT_W(2)) u_small (
        .clk(clk), .rst_n(rst_n), .run(run2),
        .mem_req(req2), .mem_addr(addr2),
        .mem_ack(ack2), .mem_rdata(rdata2), .target(target2),
        .alu_sum(s_alu), .wb(s_wb), .mem_wb(s_mwb), .imm_wb(s_iwb),
        .eq_in(s_eq), .lt_in(s_lt), .reset_st(s_rst), .set_st(s_set),
        .dest(s_dest), .source1(s_src1), .source2(s_src2),
        .pc(pc2), .halted(halted2), .retired(retired2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    endtask

    task automatic do_instr(input vec_t v);
        exp_t e;
        exp_t g;
        int   n;
        n = 0;
        while (!mem_req && n < 10) begin
            step();
            n++;
        end
        chk("req_rise", 64'(mem_req), 64'(1));
        chk("fetch_addr", 64'(mem_addr), 64'(m_pc));
        e.strb = v.word[7:0];
        e.dest = v.word[12:8];
        e.src2 = v.word[17:13];
        e.halt = v.word[30];
        if (v.word[30]) e.pc = m_pc;
        else if (v.word[31]) e.pc = m_pc + {27'd0, v.tgt};
        else e.pc = m_pc + 32'd1;
        e.ret = m_ret + 16'd1;
        sb.push_back(e);
        for (int k = 0; k < v.dly; k++) begin
            chk("wait_hold", 64'({mem_req, mem_addr, w_strb}),
                64'({1'b1, m_pc, 8'h00}));
            step();
        end
        mem_ack   = 1'b1;
        mem_rdata = v.word;
        step();
        mem_rdata = ~v.word;
        chk("decode_quiet", 64'({mem_req, w_strb}), 64'(0));
        step();
        mem_ack = 1'b0;
        target  = v.tgt;
        run     = v.run_nx;
        g = sb.pop_front();
        chk("exec_strb", 64'(w_strb), 64'(g.strb));
        chk("exec_dest", 64'(dest), 64'(g.dest));
        chk("exec_src1", 64'(source1), 64'(g.dest));
        chk("exec_src2", 64'(source2), 64'(g.src2));
        step();
        target = 5'd0;
        m_pc   = g.pc;
        m_ret  = g.ret;
        chk("pc_next", 64'(pc), 64'(g.pc));
        chk("retired", 64'(retired), 64'(g.ret));
        chk("halted", 64'(halted), 64'(g.halt));
        chk("strb_clear", 64'(w_strb), 64'(0));
        if (!v.run_nx) begin
            for (int k = 0; k < 3; k++) begin
                chk("idle_noreq", 64'(mem_req), 64'(0));
                step();
            end
            run = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{32'h0000_2203, 5'd0,  0, 1'b1};
        tbl[1] = '{32'h8000_0000, 5'd9,  0, 1'b1};
        tbl[2] = '{32'h8000_0000, 5'd0,  1, 1'b1};
        tbl[3] = '{32'h8000_0000, 5'd5,  2, 1'b1};
        tbl[4] = '{32'h0003_F0FF, 5'd3,  4, 1'b1};
        tbl[5] = '{32'hBFFC_0000, 5'd31, 0, 1'b1};
        tbl[6] = '{32'h0000_1FA5, 5'd7,  1, 1'b0};
        tbl[7] = '{32'h4000_0001, 5'd4,  0, 1'b1};

        rst_n = 1'b0;
        run = 1'b0; mem_ack = 1'b0; mem_rdata = '0; target = '0;
        run2 = 1'b0; ack2 = 1'b0; rdata2 = '0; target2 = '0;
        m_pc = '0; m_ret = '0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("rst_req", 64'(mem_req), 64'(0));
        chk("rst_pc", 64'(pc), 64'(0));
        chk("rst_ret", 64'(retired), 64'(0));
        chk("rst_halt", 64'(halted), 64'(0));
        chk("rst_strb", 64'({w_strb, dest, source2}), 64'(0));

        run = 1'b1;
        step();
        chk("first_req", 64'({mem_req, mem_addr}), 64'({1'b1, 32'd0}));
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_req", 64'(mem_req), 64'(0));
        chk("async_rst_pc", 64'(pc), 64'(0));
        chk("async_rst_strb", 64'(w_strb), 64'(0));
        run = 1'b0;
        #1;
        rst_n = 1'b1;
        step();
        step();
        chk("idle_after_rst", 64'(mem_req), 64'(0));

        run = 1'b1;
        foreach (tbl[i]) do_instr(tbl[i]);

        for (int k = 0; k < 5; k++) begin
            run       = k[0];
            mem_ack   = ~k[0];
            mem_rdata = 32'h0000_00FF;
            step();
            chk("halt_noreq", 64'(mem_req), 64'(0));
            chk("halt_state", 64'({halted, pc, retired}),
                64'({1'b1, m_pc, m_ret}));
            chk("halt_strb", 64'(w_strb), 64'(0));
        end
        mem_ack = 1'b0;

        run2 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [3:0] epc;
            logic [1:0] eret;
            int         n;
            n = 0;
            while (!req2 && n < 10) begin
                step();
                n++;
            end
            epc  = (k == 0) ? 4'd15 : 4'(k - 1);
            eret = 2'(k + 1);
            chk("w_req", 64'(req2), 64'(1));
            chk("w_addr", 64'(addr2),
                64'((k == 0) ? 4'd0 : ((k == 1) ? 4'd15 : 4'(k - 2))));
            ack2   = 1'b1;
            rdata2 = (k == 0) ? 32'h8000_0000 : 32'h0000_0000;
            step();
            ack2 = 1'b0;
            step();
            target2 = 5'd15;
            if (k == 3) run2 = 1'b0;
            step();
            chk("w_pc", 64'(pc2), 64'(epc));
            chk("w_ret", 64'(retired2), 64'(eret));
        end
        for (int k = 0; k < 3; k++) begin
            step();
            chk("w_idle", 64'(req2), 64'(0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
